// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V core constants: counter states, XLEN default, branch funct3 codes
package rv_pkg;

    localparam int RV_XLEN = 32;

    // 2-bit saturating branch history counter states
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Conditional branch funct3 encodings used by the comparator
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - next-state logic for a 2-bit saturating taken/not-taken counter
module sat_counter2
    import rv_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward taken or not-taken, holding at either end
    always_comb begin
        ctr_next = ctr;
        if (taken && (ctr != CTR_ST)) begin
            ctr_next = ctr + 2'd1;
        end else if (!taken && (ctr != CTR_SNT)) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and branch statistics
module branch_predictor
    import rv_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int XLEN       = RV_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lkp_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam int TAG_W = XLEN - INDEX_BITS - 2;

    logic             valid_q  [DEPTH];
    logic             valid_d  [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic [1:0]       ctr_d    [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  target_d [DEPTH];

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] lkp_idx, upd_idx;
    logic [TAG_W-1:0]      lkp_tag, upd_tag;
    logic                  upd_hit;
    logic [1:0]            upd_ctr_next;

    // Byte-offset bits never take part in indexing or tagging
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lkp_pc[1:0], upd_pc[1:0]};

    assign lkp_idx = lkp_pc[INDEX_BITS+1:2];
    assign lkp_tag = lkp_pc[XLEN-1:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[XLEN-1:INDEX_BITS+2];

    // Fetch-side lookup reads the current table contents; no bypass from the update port
    always_comb begin
        pred_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
        pred_taken  = pred_hit && ctr_q[lkp_idx][1];
        pred_target = pred_taken ? target_q[lkp_idx] : (lkp_pc + XLEN'(4));
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    // Resolved-branch training: train on hit, allocate on taken miss, ignore not-taken miss
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd_valid) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = upd_ctr_next;
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    // Statistics counters wrap naturally at 32 bits
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_valid) begin
            branch_count_d = branch_count_q + 32'd1;
            if (upd_taken != upd_pred_taken) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    // Valid bits, counters and statistics clear on reset, which overrides any update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            valid_q            <= valid_d;
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Tag and target need no reset since valid gates them; reset still blocks writes
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks of branch_predictor against a table model
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lkp_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per table slot, plain integer counter 0..3
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    int unsigned m_target [64];
    int          m_ctr    [64];
    int unsigned m_bc;
    int unsigned m_mc;

    branch_predictor #(.INDEX_BITS(6), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .lkp_pc           (lkp_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input int unsigned pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 256);
    endfunction

    function automatic bit m_taken(input int unsigned pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic int unsigned m_target_of(input int unsigned pc);
        return m_taken(pc) ? m_target[slot(pc)] : pc + 4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_update(input int unsigned pc, input bit tk, input int unsigned tgt, input bit ptk);
        int s;
        s = slot(pc);
        if (m_hit(pc)) begin
            if (tk) begin
                m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                m_target[s] = tgt;
            end else begin
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (tk) begin
            m_valid[s]  = 1'b1;
            m_tag[s]    = pc / 256;
            m_target[s] = tgt;
            m_ctr[s]    = 2;
        end
        m_bc = m_bc + 1;
        if (tk != ptk) m_mc = m_mc + 1;
    endtask

    // One resolved branch: driven for a single cycle, applied to the model at the edge
    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic ptk);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_taken = ptk;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        m_update(pc, tk, tgt, ptk);
    endtask

    task automatic look(input logic [31:0] pc);
        lkp_pc = pc;
        #1;
    endtask

    initial begin
        logic [31:0] pc, tgt, lk;
        logic        tk, ptk;

        reset = 1'b1;
        lkp_pc = 32'h0;
        upd_valid = 1'b1;
        upd_pc = 32'h0000_0300;
        upd_taken = 1'b1;
        upd_target = 32'h0000_1000;
        upd_pred_taken = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        upd_valid = 1'b0;

        // Reset state, with an update held during reset
        look(32'h0000_0300);
        check("reset_prio_hit", {31'b0, pred_hit}, 32'd0);
        look(32'h0000_0100);
        check("reset_hit", {31'b0, pred_hit}, 32'd0);
        check("reset_taken", {31'b0, pred_taken}, 32'd0);
        check("reset_target", pred_target, 32'h0000_0104);
        check("reset_bc", branch_count, 32'd0);
        check("reset_mc", mispredict_count, 32'd0);

        // Allocate and predict
        do_update(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
        look(32'h0000_0100);
        check("alloc_hit", {31'b0, pred_hit}, 32'd1);
        check("alloc_taken", {31'b0, pred_taken}, 32'd1);
        check("alloc_target", pred_target, 32'h0000_0080);
        check("alloc_bc", branch_count, 32'd1);
        check("alloc_mc", mispredict_count, 32'd1);

        // Saturate high, then hysteresis on the way down
        do_update(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
        do_update(32'h0000_0100, 1'b0, 32'h0000_0080, 1'b1);
        look(32'h0000_0100);
        check("hyst_nt1_taken", {31'b0, pred_taken}, 32'd1);
        do_update(32'h0000_0100, 1'b0, 32'h0000_0080, 1'b1);
        look(32'h0000_0100);
        check("hyst_nt2_taken", {31'b0, pred_taken}, 32'd0);
        check("hyst_nt2_hit", {31'b0, pred_hit}, 32'd1);
        check("hyst_nt2_target", pred_target, 32'h0000_0104);
        repeat (4) do_update(32'h0000_0100, 1'b0, 32'h0000_0080, 1'b0);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
        look(32'h0000_0100);
        check("sat_low_taken", {31'b0, pred_taken}, 32'd0);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0088, 1'b0);
        look(32'h0000_0100);
        check("sat_low_up2_taken", {31'b0, pred_taken}, 32'd1);
        check("sat_low_up2_target", pred_target, 32'h0000_0088);
        check("train_bc", branch_count, m_bc);
        check("train_mc", mispredict_count, m_mc);

        // Alias eviction: 0x200 shares slot 0 with 0x100
        do_update(32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1);
        look(32'h0000_0100);
        check("alias_old_hit", {31'b0, pred_hit}, 32'd0);
        check("alias_old_target", pred_target, 32'h0000_0104);
        look(32'h0000_0200);
        check("alias_new_hit", {31'b0, pred_hit}, 32'd1);
        check("alias_new_target", pred_target, 32'h0000_0400);
        do_update(32'h0000_0200, 1'b0, 32'h0000_0400, 1'b1);
        look(32'h0000_0200);
        check("alias_new_weak", {31'b0, pred_taken}, 32'd0);

        // Same-cycle lookup and update: lookup sees pre-update contents
        do_update(32'h0000_0100, 1'b1, 32'h0000_0090, 1'b0);
        lkp_pc = 32'h0000_0100;
        upd_valid = 1'b1;
        upd_pc = 32'h0000_0100;
        upd_taken = 1'b0;
        upd_target = 32'h0;
        upd_pred_taken = 1'b1;
        #1;
        check("same_cycle_taken", {31'b0, pred_taken}, 32'd1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        m_update(32'h0000_0100, 1'b0, 32'h0, 1'b1);
        #1;
        check("next_cycle_taken", {31'b0, pred_taken}, 32'd0);

        // Not-taken miss leaves the aliased entry alone; target wraps at the top of memory
        do_update(32'h0000_0500, 1'b0, 32'h0000_0700, 1'b0);
        look(32'h0000_0100);
        check("nt_miss_keeps_hit", {31'b0, pred_hit}, 32'd1);
        look(32'hFFFF_FFFC);
        check("wrap_target", pred_target, 32'h0000_0000);

        // Statistics counter wrap
        dut.branch_count_q = 32'hFFFF_FFFF;
        m_bc = 32'hFFFF_FFFF;
        do_update(32'h0000_0040, 1'b0, 32'h0, 1'b0);
        check("bc_wrap", branch_count, 32'd0);

        // Randomized traffic over a small PC pool so aliasing and saturation recur
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
            lk  = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) lk = 32'hFFFF_FFFC | $urandom_range(0, 3);
            tk  = 1'($urandom_range(0, 3) != 0 ? (pc[4] ^ pc[8]) : $urandom_range(0, 1));
            tgt = $urandom & 32'hFFFF_FFFC;
            ptk = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : m_taken(pc);
            upd_valid      = 1'($urandom_range(0, 4) != 0);
            upd_pc         = pc;
            upd_taken      = tk;
            upd_target     = tgt;
            upd_pred_taken = ptk;
            lkp_pc         = lk;
            #1;
            if (n % 8 == 0) begin
                check("rnd_hit", {31'b0, pred_hit}, {31'b0, m_hit(lk)});
                check("rnd_taken", {31'b0, pred_taken}, {31'b0, m_taken(lk)});
                check("rnd_target", pred_target, m_target_of(lk));
            end
            @(posedge clk);
            #1;
            if (upd_valid) m_update(pc, tk, tgt, ptk);
        end
        upd_valid = 1'b0;
        #1;
        check("rnd_bc", branch_count, m_bc);
        check("rnd_mc", mispredict_count, m_mc);

        // Mid-stream reset discards the concurrent update
        reset = 1'b1;
        upd_valid = 1'b1;
        upd_pc = 32'h0000_0C3C;
        upd_taken = 1'b1;
        upd_target = 32'h0000_2000;
        upd_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        upd_valid = 1'b0;
        m_reset();
        look(32'h0000_0C3C);
        check("midrst_hit", {31'b0, pred_hit}, 32'd0);
        check("midrst_target", pred_target, 32'h0000_0C40);
        look(32'h0000_0100);
        check("midrst_old_hit", {31'b0, pred_hit}, 32'd0);
        check("midrst_bc", branch_count, m_bc);
        check("midrst_mc", mispredict_count, m_mc);

        // Counters restart from weak-not-taken: one taken miss allocates to weak-taken
        do_update(32'h0000_0100, 1'b1, 32'h0000_0300, 1'b1);
        look(32'h0000_0100);
        check("post_rst_taken", {31'b0, pred_taken}, 32'd1);
        check("post_rst_bc", branch_count, 32'd1);
        check("post_rst_mc", mispredict_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RISC-V core: a direct-mapped branch target buffer (BTB) with a 2-bit saturating-counter history table. It supplies a taken/not-taken guess and target at fetch, and it learns from branch outcomes resolved downstream by the branch comparator (`branch_taken`) in execute. Lookups are combinational. Updates, occupancy, and statistics counters are registered. The block is the producer of branch predictions; the comparator is the resolver.

## Interface
- `INDEX_BITS`, default 6: table depth = 2^INDEX_BITS entries.
- `XLEN`, default 32: PC and target width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `lkp_pc` input XLEN: fetch PC to predict.
- `pred_hit` output 1: BTB entry valid and tag matches `lkp_pc`.
- `pred_taken` output 1: `pred_hit` && counter[1].
- `pred_target` output XLEN: stored target if `pred_taken`, else `lkp_pc + 4`.
- `upd_valid` input 1: one resolved conditional branch this cycle.
- `upd_pc` input XLEN: PC of the resolved branch.
- `upd_taken` input 1: comparator outcome.
- `upd_target` input XLEN: computed branch target.
- `upd_pred_taken` input 1: the prediction issued for this branch, carried down the pipe.
- `branch_count` output 32: resolved branches since reset.
- `mispredict_count` output 32: resolved branches where `upd_taken` != `upd_pred_taken`.

## Operation
- Index = `pc[INDEX_BITS+1:2]`. Tag = `pc[XLEN-1:INDEX_BITS+2]`. `pc[1:0]` is ignored.
- Each entry holds: `valid` (1 bit), `tag`, `target` (XLEN), and `ctr` (2 bits).
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Update rule, evaluated on `upd_valid`, where hit means `valid` && tag match at the `upd_pc` index:
  - Hit, taken: `ctr` = min(`ctr`+1, 3); `target` = `upd_target`.
  - Hit, not taken: `ctr` = max(`ctr`-1, 0).
  - Miss, taken: allocate the entry (replacing any other tag). Set `valid`=1, write tag and target, `ctr`=10.
  - Miss, not taken: no table change.
- Statistics counters:
  - `branch_count` increments on every `upd_valid`.
  - `mispredict_count` increments when `upd_valid` && (`upd_taken` != `upd_pred_taken`).
  - Both wrap from 0xFFFF_FFFF to 0 with no saturation.
- `upd_valid`=0: no state changes, and `upd_*` inputs are don't-care.
- `pred_target` addition is modulo 2^XLEN, so `lkp_pc` = 0xFFFF_FFFC yields 0x0000_0000.

## Timing
- Lookup path is purely combinational: `lkp_pc` → `pred_*` in the same cycle.
- An update is written at the rising edge of the cycle in which `upd_valid`=1. It is visible to lookups from the next cycle onward.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents. There is no bypass.
- Back-to-back updates to one entry on consecutive cycles each see the prior cycle's result. Saturation holds at both ends.
- Reset, taking priority over any concurrent update:
  - All `valid` bits = 0.
  - All `ctr` = 01.
  - Both statistics counters = 0.
  - `tag` and `target` need not be cleared.
- Reset-driven outputs in the cycle after reset:
  - `pred_hit` = 0 and `pred_taken` = 0.
  - `pred_target` = `lkp_pc + 4`.
  - `branch_count` = 0 and `mispredict_count` = 0.
- Reset asserted mid-stream discards any in-flight update in that cycle. No partial writes occur.

## Structure
- Shared package `rv_pkg`: counter-state constants (`CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`) and the `XLEN` default. The comparator funct3 codes also belong in this package.
- Sub-module `sat_counter2`: pure-function next-state logic for the 2-bit counter (inputs `ctr`, `taken`; output `ctr_next`). Instantiate one in the update path.
- Tables are flat register arrays. There are no RAM macros, because reset must clear `valid` and `ctr` in one cycle.

## Test plan
- **Reset then lookup:** lookup 0x0000_0100 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0x0000_0104. Both counts read 0.
- **Allocate and predict:** update {pc=0x100, taken=1, target=0x80, pred_taken=0}, then lookup 0x100 → `pred_hit`=1, `pred_taken`=1, `pred_target`=0x80. Counts read `branch_count`=1, `mispredict_count`=1.
- **Saturation and hysteresis:**
  - 3 taken updates on pc 0x100 → `ctr`=11.
  - Then 1 not-taken update → `pred_taken` still 1.
  - A 2nd not-taken update → `pred_taken`=0.
  - 4 further not-taken updates → `ctr` remains 00.
- **Alias eviction:** with INDEX_BITS=6, allocate pc 0x100 then a taken update at 0x200 (same index, different tag) → lookup 0x100 gives `pred_hit`=0. Lookup 0x200 gives `pred_hit`=1, `ctr`=10.
- **Same-cycle lookup/update:** lookup 0x100 while updating 0x100 not-taken from `ctr`=10 → `pred_taken`=1 that cycle, 0 the next cycle.
- **Reset priority and counter wrap:**
  - Assert `reset` together with `upd_valid` → no entry becomes valid.
  - Force `branch_count` to 0xFFFF_FFFF by hierarchical deposit, then one update → `branch_count`=0.
